// File: rtl/line_mem_responder_if.sv
// ----------------------------------------------------------------------------
// line_mem_responder_if
// Bundles the cache line-refill / write-back handshake between the cache
// master port and the memory-side responder.
//   i_addr           : line address (master -> slave)
//   i_byte_en        : per-32-bit-word write enables
//   i_writedata      : 128-bit write line
//   i_read, i_write  : requests, held until accepted
//   o_readdata       : 128-bit read line (slave -> master)
//   o_readdata_valid : one-cycle pulse qualifying o_readdata
//   o_waitrequest    : high = request not accepted this cycle
// ----------------------------------------------------------------------------
interface line_mem_responder_if #(
    parameter int ADDR_W = 26
);
    logic [ADDR_W-1:0] i_addr;
    logic [3:0]        i_byte_en;
    logic [127:0]      i_writedata;
    logic              i_read;
    logic              i_write;
    logic [127:0]      o_readdata;
    logic              o_readdata_valid;
    logic              o_waitrequest;

    modport master (
        output i_addr, i_byte_en, i_writedata, i_read, i_write,
        input  o_readdata, o_readdata_valid, o_waitrequest
    );

    modport slave (
        input  i_addr, i_byte_en, i_writedata, i_read, i_write,
        output o_readdata, o_readdata_valid, o_waitrequest
    );
endinterface

// File: rtl/line_mem_responder.sv
// ----------------------------------------------------------------------------
// line_mem_responder
// Memory-side responder for the cache line master port: 2^DEPTH_LOG2 lines of
// 128 bits, per-word write enables, programmable read and write latency.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : line_mem_responder_if.slave (request/response handshake)
// Optional build macro: LINE_MEM_STALL_EN adds an 8-bit LFSR that injects
// random backpressure while idle.
// The line array is deliberately outside the reset domain.
// ----------------------------------------------------------------------------
module line_mem_responder #(
    parameter int DEPTH_LOG2    = 6,
    parameter int ADDR_W        = 26,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    line_mem_responder_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = (WRITE_LATENCY > 0) ? 4'(WRITE_LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2,
        WR_WAIT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [3:0]              be_q, be_d;
    logic [127:0]            wdata_q, wdata_d;
    logic [127:0]            readdata_q;
    logic                    valid_q;
    logic [127:0]            mem_q [DEPTH];

    logic                    stall_s;
    logic                    waitreq_s;
    logic [DEPTH_LOG2-1:0]   addr_idx_s;
    logic [DEPTH_LOG2-1:0]   rd_idx_s;
    logic                    wr_en_s;
    logic [DEPTH_LOG2-1:0]   wr_idx_s;
    logic [3:0]              wr_be_s;
    logic [127:0]            wr_data_s;
    logic                    addr_hi_unused_s;

    // Upper address bits alias onto the same lines.
    assign addr_idx_s       = bus.i_addr[DEPTH_LOG2-1:0];
    assign addr_hi_unused_s = ^bus.i_addr[ADDR_W-1:DEPTH_LOG2];

`ifdef LINE_MEM_STALL_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall_s = (lfsr_q[1:0] == 2'b11);
`else
    assign stall_s = 1'b0;
`endif

    // Stall depends only on registered state, never on the request lines.
    assign waitreq_s = (state_q != IDLE) || stall_s;

    // Next-state, latch capture and array-write control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rd_idx_s  = idx_q;
        wr_en_s   = 1'b0;
        wr_idx_s  = idx_q;
        wr_be_s   = be_q;
        wr_data_s = wdata_q;
        case (state_q)
            IDLE: begin
                rd_idx_s = addr_idx_s;
                // A write wins when both requests are raised; the read is dropped.
                if (!waitreq_s && bus.i_write) begin
                    if (WRITE_LATENCY == 0) begin
                        wr_en_s   = 1'b1;
                        wr_idx_s  = addr_idx_s;
                        wr_be_s   = bus.i_byte_en;
                        wr_data_s = bus.i_writedata;
                    end else begin
                        state_d = WR_WAIT;
                        cnt_d   = WR_LOAD;
                        idx_d   = addr_idx_s;
                        be_d    = bus.i_byte_en;
                        wdata_d = bus.i_writedata;
                    end
                end else if (!waitreq_s && bus.i_read) begin
                    idx_d = addr_idx_s;
                    if (READ_LATENCY == 1) begin
                        state_d = RD_RESP;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = RD_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                // Counter reaching zero coincides with entering RD_RESP.
                if (cnt_q <= 4'd1) begin
                    state_d = RD_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_RESP: begin
                state_d = IDLE;
            end
            WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    wr_en_s = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers and registered read response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            be_q       <= 4'd0;
            wdata_q    <= 128'd0;
            readdata_q <= 128'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            valid_q <= (state_d == RD_RESP);
            if (state_d == RD_RESP) begin
                readdata_q <= mem_q[rd_idx_s];
            end
        end
    end

    // Line array with per-word write enables.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be_s[k]) begin
                    mem_q[wr_idx_s][32*k +: 32] <= wr_data_s[32*k +: 32];
                end
            end
        end
    end

    assign bus.o_readdata       = readdata_q;
    assign bus.o_readdata_valid = valid_q;
    assign bus.o_waitrequest    = waitreq_s;
endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;
    localparam int RL  = 2;
    localparam int WL  = 1;
    localparam int DL2 = 6;
    localparam int AW  = 26;
`ifdef LINE_MEM_STALL_EN
    localparam int NOPS = 1000;
`else
    localparam int NOPS = 300;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    line_mem_responder_if #(.ADDR_W(AW)) bus();

    line_mem_responder #(
        .DEPTH_LOG2(DL2), .ADDR_W(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: flat line array plus expected busy window / response.
    logic [127:0] shadow [64];
    int           busy_until = -1;
    int           resp_cyc   = -1;
    logic [127:0] resp_data  = 128'd0;
    bit           mon_en     = 1'b0;
    int           idle_stalls = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && rst) begin
`ifdef LINE_MEM_STALL_EN
            if (cyc <= busy_until) chk("waitrequest_busy", 128'(bus.o_waitrequest), 128'd1);
            else if (bus.o_waitrequest) idle_stalls++;
`else
            chk("waitrequest", 128'(bus.o_waitrequest), 128'(cyc <= busy_until));
`endif
            chk("readdata_valid", 128'(bus.o_readdata_valid), 128'(cyc == resp_cyc));
            if (cyc == resp_cyc) chk("readdata", bus.o_readdata, resp_data);
        end
    end

    // Drive one request, wait for acceptance (bounded), update the model.
    task automatic req(bit rd, bit wr, int addr, logic [3:0] be, logic [127:0] d,
                       bit upd, output int t);
        int n;
        int idx;
        n = 0;
        @(negedge clk);
        bus.i_read = rd; bus.i_write = wr; bus.i_addr = AW'(addr);
        bus.i_byte_en = be; bus.i_writedata = d;
        while (bus.o_waitrequest && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no acceptance required acceptance within 200 cycles");
            bus.i_read = 1'b0; bus.i_write = 1'b0;
            t = -1;
            return;
        end
        @(posedge clk);
        #1;
        t = cyc;
        bus.i_read = 1'b0; bus.i_write = 1'b0;
        idx = addr % 64;
        if (wr) begin
            if (upd) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) shadow[idx][32*k +: 32] = d[32*k +: 32];
            end
            if (WL > 0) busy_until = t + WL - 1;
        end else if (rd) begin
            busy_until = t + RL - 1;
            resp_cyc   = t + RL - 1;
            resp_data  = shadow[idx];
        end
    endtask

    task automatic read_cap(int addr, output logic [127:0] d);
        int t;
        req(1'b1, 1'b0, addr, 4'hF, 128'd0, 1'b1, t);
        d = 128'd0;
        for (int k = 0; k < RL + 3; k++) begin
            @(negedge clk);
            if (bus.o_readdata_valid) begin
                d = bus.o_readdata;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        busy_until = -1;
        resp_cyc   = -1;
        #1;
        chk("rst_waitrequest", 128'(bus.o_waitrequest), 128'd0);
        chk("rst_valid", 128'(bus.o_readdata_valid), 128'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int t;
        logic [127:0] got;
        logic [127:0] dpat;
        for (int i = 0; i < 64; i++) shadow[i] = 128'd0;
        bus.i_read = 1'b0; bus.i_write = 1'b0; bus.i_addr = '0;
        bus.i_byte_en = 4'h0; bus.i_writedata = 128'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_waitrequest", 128'(bus.o_waitrequest), 128'd0);
        chk("reset_valid", 128'(bus.o_readdata_valid), 128'd0);
        chk("reset_readdata", bus.o_readdata, 128'd0);
        #1 rst = 1'b1;
        mon_en = 1'b1;

        // Full write then read of line 3
        req(1'b0, 1'b1, 3, 4'hF, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b1, t);
        read_cap(3, got);
        chk("line3", got, 128'h0123456789ABCDEF0123456789ABCDEF);

        // Partial word enables on line 5
        req(1'b0, 1'b1, 5, 4'hF, {4{32'hFFFFFFFF}}, 1'b1, t);
        req(1'b0, 1'b1, 5, 4'b0101, 128'd0, 1'b1, t);
        read_cap(5, got);
        chk("line5_partial", got, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);

        // No-op write with all enables clear
        req(1'b0, 1'b1, 5, 4'h0, 128'd0, 1'b1, t);
        read_cap(5, got);
        chk("line5_noop", got, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);

        // Address aliasing: 0x41 and 0x01 share a line
        req(1'b0, 1'b1, 32'h41, 4'hF, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 1'b1, t);
        read_cap(32'h01, got);
        chk("alias_0x41", got, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);

        // Reset while a read is pending: no valid pulse afterwards
        req(1'b1, 1'b0, 3, 4'hF, 128'd0, 1'b1, t);
        pulse_reset();
        for (int k = 0; k < RL + 2; k++) begin
            @(negedge clk);
            chk("no_valid_after_rst", 128'(bus.o_readdata_valid), 128'd0);
        end

        // Reset while a write is pending: line 3 keeps its old contents
        req(1'b0, 1'b1, 3, 4'hF, 128'h55555555_66666666_77777777_88888888, 1'b0, t);
        pulse_reset();
        read_cap(3, got);
        chk("line3_after_wr_rst", got, 128'h0123456789ABCDEF0123456789ABCDEF);

        // Read and write together: write taken, read dropped
        req(1'b1, 1'b1, 7, 4'hF, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1'b1, t);
        for (int k = 0; k < RL + 2; k++) begin
            @(negedge clk);
            chk("dropped_read_no_valid", 128'(bus.o_readdata_valid), 128'd0);
        end
        read_cap(7, got);
        chk("line7", got, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);

        // Fill every line, then random traffic against the model
        for (int i = 0; i < 64; i++) begin
            dpat = {$urandom, $urandom, $urandom, $urandom};
            req(1'b0, 1'b1, i, 4'hF, dpat, 1'b1, t);
        end
        for (int i = 0; i < NOPS; i++) begin
            int a;
            a = int'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) begin
                dpat = {$urandom, $urandom, $urandom, $urandom};
                req(1'b0, 1'b1, a, 4'($urandom_range(0, 15)), dpat, 1'b1, t);
            end else begin
                req(1'b1, 1'b0, a, 4'hF, 128'd0, 1'b1, t);
            end
        end
        repeat (RL + 3) @(negedge clk);
`ifdef LINE_MEM_STALL_EN
        chk("idle_stall_seen", 128'(idle_stalls > 0), 128'd1);
`endif
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
